// File: rtl/mod_down_counter.sv
// Loadable modulo-MOD down counter used as an interval / timeout generator.
// A load captures a clamped start value. Each enabled cycle decrements the count.
// An enabled cycle at zero raises a one-cycle terminal-count pulse, then either
// reloads the captured start value (periodic) or parks in DONE (one-shot).
module mod_down_counter #(
  parameter int WIDTH = 4,
  parameter int MOD   = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             enable,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Largest legal count. MOD may equal 2**WIDTH, so MOD-1 always fits in WIDTH bits.
  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MOD - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic [WIDTH-1:0] reload_reg, reload_nxt;
  logic             tc_nxt;

  // Saturate an out-of-range start value to the top of the modulus range.
  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    return (v > MAX_CNT) ? MAX_CNT : v;
  endfunction

  // Next-state and next-datapath decode. Load has priority over counting in every state.
  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    reload_nxt = reload_reg;
    tc_nxt     = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (load) begin
          count_nxt  = clamp_load(data_in);
          reload_nxt = clamp_load(data_in);
          state_nxt  = S_RUN;
        end
      end
      S_RUN: begin
        if (load) begin
          count_nxt  = clamp_load(data_in);
          reload_nxt = clamp_load(data_in);
        end else if (enable) begin
          if (count != '0) begin
            count_nxt = count - WIDTH'(1);
          end else begin
            // Zero is the terminal state of a period. There is no wrap below zero.
            tc_nxt = 1'b1;
            if (auto_reload) begin
              count_nxt = reload_reg;
            end else begin
              state_nxt = S_DONE;
            end
          end
        end
      end
      default: begin
        state_nxt = S_IDLE;
        count_nxt = '0;
      end
    endcase
  end

  // State register. An asynchronous reset discards any run in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Count, captured start value and terminal-count pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count      <= '0;
      reload_reg <= '0;
      tc         <= 1'b0;
    end else begin
      count      <= count_nxt;
      reload_reg <= reload_nxt;
      tc         <= tc_nxt;
    end
  end

  // Status is decoded straight from the state register, so it has no input-to-output path.
  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_mod_down_counter.sv
// Self-checking bench for mod_down_counter (WIDTH=4, MOD=12).
// Table vectors are pushed to a scoreboard queue when they are driven.
// They are popped and compared one time unit after the next rising edge.
module tb_mod_down_counter;

  localparam int WIDTH = 4;
  localparam int MOD   = 12;

  logic             clk;
  logic             rst;
  logic             load;
  logic [WIDTH-1:0] data_in;
  logic             enable;
  logic             auto_reload;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             busy;
  logic             done;

  typedef struct {
    string            name;
    logic             ld;
    logic [WIDTH-1:0] din;
    logic             en;
    logic             ar;
    logic [WIDTH-1:0] ecount;
    logic             etc;
    logic             ebusy;
    logic             edone;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   n_run  = 0;
  int   n_fail = 0;

  mod_down_counter #(.WIDTH(WIDTH), .MOD(MOD)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .data_in    (data_in),
    .enable     (enable),
    .auto_reload(auto_reload),
    .count      (count),
    .tc         (tc),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
    n_run++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, expv);
    end
  endtask

  task automatic add(input string nm, input logic ld, input logic [WIDTH-1:0] din,
                     input logic en, input logic ar, input logic [WIDTH-1:0] ec,
                     input logic et, input logic eb, input logic ed);
    vec_t v;
    v.name = nm; v.ld = ld; v.din = din; v.en = en; v.ar = ar;
    v.ecount = ec; v.etc = et; v.ebusy = eb; v.edone = ed;
    vecs.push_back(v);
  endtask

  task automatic apply(input vec_t v);
    vec_t e;
    @(negedge clk);
    load        = v.ld;
    data_in     = v.din;
    enable      = v.en;
    auto_reload = v.ar;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({e.name, ".count"}, 32'(count), 32'(e.ecount));
    chk({e.name, ".tc"},    32'(tc),    32'(e.etc));
    chk({e.name, ".busy"},  32'(busy),  32'(e.ebusy));
    chk({e.name, ".done"},  32'(done),  32'(e.edone));
  endtask

  task automatic check_idle(input string nm);
    chk({nm, ".count"}, 32'(count), 32'd0);
    chk({nm, ".tc"},    32'(tc),    32'd0);
    chk({nm, ".busy"},  32'(busy),  32'd0);
    chk({nm, ".done"},  32'(done),  32'd0);
  endtask

  initial begin
    vec_t v;
    // Fill the vector table: name, load, data_in, enable, auto_reload -> count, tc, busy, done
    add("idle_en_ignored", 0, 4'd9, 1, 0, 4'd0, 0, 0, 0);
    // Clamped one-shot: 13 -> 11, twelve enabled edges to tc.
    add("clamp_load", 1, 4'd13, 0, 0, 4'd11, 0, 1, 0);
    for (int i = 10; i >= 0; i--) add("clamp_dec", 0, 4'd0, 1, 0, 4'(i), 0, 1, 0);
    add("clamp_tc",        0, 4'd0, 1, 0, 4'd0, 1, 0, 1);
    add("done_hold",       0, 4'd0, 1, 1, 4'd0, 0, 0, 1);
    // Zero load, then restart from DONE.
    add("zero_load",       1, 4'd0, 0, 0, 4'd0, 0, 1, 0);
    add("zero_tc",         0, 4'd0, 1, 0, 4'd0, 1, 0, 1);
    add("restart_done",    1, 4'd2, 0, 0, 4'd2, 0, 1, 0);
    // Auto-reload with start value 3: period of 4 enabled cycles.
    add("ar_load",         1, 4'd3, 0, 1, 4'd3, 0, 1, 0);
    for (int i = 0; i < 12; i++)
      add("ar_run", 0, 4'd0, 1, 1, (i % 4 == 3) ? 4'd3 : 4'(2 - i % 4),
          (i % 4 == 3), 1, 0);
    // Enable gaps.
    add("gap_load",        1, 4'd4, 0, 0, 4'd4, 0, 1, 0);
    add("gap_e1",          0, 4'd0, 1, 0, 4'd3, 0, 1, 0);
    add("gap_e2",          0, 4'd0, 1, 0, 4'd2, 0, 1, 0);
    add("gap_h1",          0, 4'd0, 0, 0, 4'd2, 0, 1, 0);
    add("gap_h2",          0, 4'd0, 0, 0, 4'd2, 0, 1, 0);
    add("gap_e3",          0, 4'd0, 1, 0, 4'd1, 0, 1, 0);
    add("gap_e4",          0, 4'd0, 1, 0, 4'd0, 0, 1, 0);
    add("gap_tc",          0, 4'd0, 1, 0, 4'd0, 1, 0, 1);
    // Load has priority over an enabled cycle at zero.
    add("prio_load1",      1, 4'd1, 0, 0, 4'd1, 0, 1, 0);
    add("prio_dec",        0, 4'd0, 1, 0, 4'd0, 0, 1, 0);
    add("prio_load7",      1, 4'd7, 1, 0, 4'd7, 0, 1, 0);
    add("prio_hold",       0, 4'd0, 0, 0, 4'd7, 0, 1, 0);
    add("run_reload_mid",  1, 4'd15, 1, 0, 4'd11, 0, 1, 0);
    // A reload value of zero in periodic mode pulses tc on every enabled cycle.
    add("ar0_load",        1, 4'd0, 0, 1, 4'd0, 0, 1, 0);
    add("ar0_tc1",         0, 4'd0, 1, 1, 4'd0, 1, 1, 0);
    add("ar0_tc2",         0, 4'd0, 1, 1, 4'd0, 1, 1, 0);
    add("ar0_tc3",         0, 4'd0, 1, 1, 4'd0, 1, 1, 0);
    add("ar0_to_oneshot",  0, 4'd0, 1, 0, 4'd0, 1, 0, 1);
    add("max_load",        1, 4'd11, 0, 0, 4'd11, 0, 1, 0);

    rst = 1'b0; load = 1'b0; data_in = '0; enable = 1'b0; auto_reload = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset_init");
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) apply(vecs[i]);

    // Reset mid-run: load 5, two enabled edges, then an asynchronous reset between edges.
    v.name = "rr_load"; v.ld = 1; v.din = 4'd5; v.en = 0; v.ar = 0;
    v.ecount = 4'd5; v.etc = 0; v.ebusy = 1; v.edone = 0;
    apply(v);
    v.name = "rr_dec"; v.ld = 0; v.en = 1; v.ecount = 4'd4;
    apply(v);
    v.ecount = 4'd3;
    apply(v);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_idle("reset_async");
    load = 1'b1; data_in = 4'd6; enable = 1'b1;
    @(posedge clk);
    #1;
    check_idle("reset_held");
    @(negedge clk);
    rst = 1'b1; load = 1'b0;
    @(posedge clk);
    #1;
    check_idle("reset_released");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/mod_down_counter.md
Name: mod_down_counter

Overview:
- Loadable modulo-N down counter (countdown timer); the count-down counterpart of the team's loadable mod-12 up counter.
- Loads a start value, decrements on enable, and flags terminal count with a one-cycle pulse.
- Either stops at zero (one-shot) or reloads the captured start value (periodic).
- Used as an interval/timeout generator next to the up counter in the MOD12 block set.

Parameters:
WIDTH, 4, bit width of data_in and count
MOD, 12, modulus; legal count range 0..MOD-1; requires 2 <= MOD <= 2**WIDTH

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  asynchronous, active-low reset
load  input  1  synchronous load strobe; captures data_in
data_in  input  WIDTH  start value to load
enable  input  1  count-down enable (ignored while load=1)
auto_reload  input  1  1: periodic mode, 0: one-shot mode; sampled each cycle
count  output  WIDTH  current count value (registered)
tc  output  1  terminal-count pulse, one cycle wide (registered)
busy  output  1  high while state is RUN
done  output  1  high while state is DONE

Behaviour:
- Reset (rst=0, asynchronous, takes effect immediately):
  - state=IDLE, count=0, reload_reg=0, tc=0, busy=0, done=0.
  - Reset released mid-run: the block restarts from IDLE, and the run in progress is discarded.
- Load clamp: loaded value = data_in if data_in <= MOD-1, else MOD-1. Example: MOD=12, data_in=13 gives 11.
- State machine has three states: IDLE, RUN, DONE.
- IDLE:
  - count holds; enable is ignored.
  - load=1: count<=clamp(data_in), reload_reg<=clamp(data_in), next state RUN.
- RUN:
  - load=1 has priority. It restarts exactly as in IDLE, tc=0 that cycle, and no decrement occurs.
  - load=0, enable=0: count holds, tc=0.
  - load=0, enable=1, count!=0: count<=count-1, tc=0.
  - load=0, enable=1, count==0: tc=1 for the next cycle, then:
    - auto_reload=1: count<=reload_reg, stay in RUN.
    - auto_reload=0: count stays 0, next state DONE.
- DONE:
  - count=0; enable is ignored; tc=0.
  - load=1: behaves as in IDLE, next state RUN.
- Loaded value 0 is legal: the first enabled cycle after the load produces tc.
- Period: loaded value V gives tc on the (V+1)-th enabled edge after the load. In auto-reload mode the period is V+1 enabled cycles.
- Outputs: busy=(state==RUN), done=(state==DONE). Both are registered and decoded from the state register, so no combinational input-to-output path exists.
- tc is never asserted for two consecutive cycles unless reload_reg=0 in auto-reload mode with enable held; in that case tc is high every cycle.
- count never exceeds MOD-1. Arithmetic is WIDTH-bit with no wrap below 0; zero is handled by the tc rule above.

Test Plan:
1. Reset while running:
   - Stimulus: rst=0 for 2 cycles, then release; later load 5, enable for 2 cycles (count=3), then assert rst=0 mid-cycle.
   - Response: count=0, tc=0, busy=0, done=0 immediately, with no clock edge needed.
2. Clamped load, one-shot:
   - Stimulus: MOD=12, load=1, data_in=13; next cycle load=0, enable=1, auto_reload=0.
   - Response: count=11 after load, then 10..0. tc=1 only on the 12th enabled edge. done=1 and busy=0 from that edge; count stays 0.
3. Auto-reload:
   - Stimulus: load data_in=3, enable held, auto_reload=1 for 12 cycles.
   - Response: count sequence 3,2,1,0,3,2,1,0,...; tc=1 every 4th cycle; busy stays 1.
4. Enable gap:
   - Stimulus: load 4, enable 1,1,0,0,1,1,1.
   - Response: count 3,2,2,2,1,0, then tc on the last edge.
5. Load priority:
   - Stimulus: in RUN with count=0, assert load=1 (data_in=7) and enable=1 together.
   - Response: count=7, tc=0, state stays RUN.
6. Zero load and restart from DONE:
   - Stimulus: load 0, enable=1, auto_reload=0; then load 2.
   - Response: tc on the first enabled edge and done=1; load then returns to RUN with count=2.
